// File: rtl/seq_control_unit.sv
// Multi-cycle sequencer for a small bus-based processor: decodes the IR and
// steps FETCH -> T1..T3, driving register, ALU and memory control strobes.
module seq_control_unit #(
    parameter int DATA_W = 16,
    parameter int RSEL_W = 3,
    localparam int NREG = 2 ** RSEL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instr,
    input  logic [3:0]        status,
    input  logic              mem_ready,
    output logic [NREG-1:0]   rin,
    output logic [NREG-1:0]   rout,
    output logic              a_in,
    output logic              gin,
    output logic              gout,
    output logic              addsub,
    output logic              xorctrl,
    output logic              pc_in,
    output logic              pc_inc,
    output logic              ir_en,
    output logic              addr_in,
    output logic              ram_addr_sel,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              ram_out,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_T1,
        S_T2,
        S_T3,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_MV   = 4'd0;
    localparam logic [3:0] OP_MVI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_LD   = 4'd5;
    localparam logic [3:0] OP_ST   = 4'd6;
    localparam logic [3:0] OP_BR   = 4'd7;
    localparam logic [3:0] OP_HALT = 4'd8;

    state_t state;
    state_t next_state;

    logic [3:0]        opcode;
    logic [RSEL_W-1:0] rx;
    logic [RSEL_W-1:0] ry;
    logic [NREG-1:0]   sel_rx;
    logic [NREG-1:0]   sel_ry;
    logic              br_taken;

    assign opcode = instr[DATA_W-1 -: 4];
    assign rx     = instr[DATA_W-5 -: RSEL_W];
    assign ry     = instr[DATA_W-5-RSEL_W -: RSEL_W];
    assign sel_rx = {{(NREG-1){1'b0}}, 1'b1} << rx;
    assign sel_ry = {{(NREG-1){1'b0}}, 1'b1} << ry;

    // ry MSB forces an unconditional branch; otherwise ry[1:0] picks a flag.
    assign br_taken = ry[RSEL_W-1] | status[ry[1:0]];

    generate
        if (DATA_W > 4 + 2 * RSEL_W) begin : g_spare
            logic unused_spare;
            assign unused_spare = ^instr[DATA_W-5-2*RSEL_W:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Every output is forced low while reset is held, even mid-access.
    always_comb begin
        next_state   = state;
        rin          = '0;
        rout         = '0;
        a_in         = 1'b0;
        gin          = 1'b0;
        gout         = 1'b0;
        addsub       = 1'b0;
        xorctrl      = 1'b0;
        pc_in        = 1'b0;
        pc_inc       = 1'b0;
        ir_en        = 1'b0;
        addr_in      = 1'b0;
        ram_addr_sel = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        ram_out      = 1'b0;
        halted       = 1'b0;
        if (rst) begin
            case (state)
                S_FETCH: begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        ir_en      = 1'b1;
                        pc_inc     = 1'b1;
                        next_state = S_T1;
                    end
                end
                S_T1: begin
                    case (opcode)
                        OP_MV: begin
                            rout       = sel_ry;
                            rin        = sel_rx;
                            next_state = S_FETCH;
                        end
                        OP_MVI: begin
                            mem_rd = 1'b1;
                            if (mem_ready) begin
                                ram_out    = 1'b1;
                                rin        = sel_rx;
                                pc_inc     = 1'b1;
                                next_state = S_FETCH;
                            end
                        end
                        OP_ADD, OP_SUB, OP_XOR: begin
                            rout       = sel_rx;
                            a_in       = 1'b1;
                            next_state = S_T2;
                        end
                        OP_LD, OP_ST: begin
                            rout       = sel_ry;
                            addr_in    = 1'b1;
                            next_state = S_T2;
                        end
                        OP_BR: begin
                            if (br_taken) begin
                                rout  = sel_rx;
                                pc_in = 1'b1;
                            end
                            next_state = S_FETCH;
                        end
                        OP_HALT: next_state = S_HALT;
                        default: next_state = S_FETCH;
                    endcase
                end
                S_T2: begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_XOR: begin
                            rout       = sel_ry;
                            gin        = 1'b1;
                            addsub     = (opcode == OP_SUB);
                            xorctrl    = (opcode == OP_XOR);
                            next_state = S_T3;
                        end
                        OP_LD: begin
                            ram_addr_sel = 1'b1;
                            mem_rd       = 1'b1;
                            if (mem_ready) begin
                                ram_out    = 1'b1;
                                rin        = sel_rx;
                                next_state = S_FETCH;
                            end
                        end
                        OP_ST: begin
                            rout         = sel_rx;
                            ram_addr_sel = 1'b1;
                            mem_wr       = 1'b1;
                            if (mem_ready) begin
                                next_state = S_FETCH;
                            end
                        end
                        default: next_state = S_FETCH;
                    endcase
                end
                S_T3: begin
                    gout       = 1'b1;
                    rin        = sel_rx;
                    next_state = S_FETCH;
                end
                S_HALT: halted = 1'b1;
                default: next_state = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_control_unit.sv
// Self-checking bench for seq_control_unit: directed scenarios plus random
// instruction streams compared cycle by cycle against per-instruction step lists.
module tb_seq_control_unit;

    localparam int DATA_W = 16;
    localparam int RSEL_W = 3;
    localparam int NREG   = 8;

    typedef struct packed {
        logic [NREG-1:0] rin;
        logic [NREG-1:0] rout;
        logic a_in;
        logic gin;
        logic gout;
        logic addsub;
        logic xorctrl;
        logic pc_in;
        logic pc_inc;
        logic ir_en;
        logic addr_in;
        logic ram_addr_sel;
        logic mem_rd;
        logic mem_wr;
        logic ram_out;
        logic halted;
    } outs_t;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] instr;
    logic [3:0]        status;
    logic              mem_ready;
    logic [NREG-1:0]   rin;
    logic [NREG-1:0]   rout;
    logic a_in, gin, gout, addsub, xorctrl, pc_in, pc_inc, ir_en, addr_in;
    logic ram_addr_sel, mem_rd, mem_wr, ram_out, halted;

    outs_t obs;
    int    tests  = 0;
    int    failed = 0;

    seq_control_unit #(.DATA_W(DATA_W), .RSEL_W(RSEL_W)) dut (
        .clk(clk), .rst(rst), .instr(instr), .status(status), .mem_ready(mem_ready),
        .rin(rin), .rout(rout), .a_in(a_in), .gin(gin), .gout(gout),
        .addsub(addsub), .xorctrl(xorctrl), .pc_in(pc_in), .pc_inc(pc_inc),
        .ir_en(ir_en), .addr_in(addr_in), .ram_addr_sel(ram_addr_sel),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .ram_out(ram_out), .halted(halted)
    );

    assign obs = {rin, rout, a_in, gin, gout, addsub, xorctrl, pc_in, pc_inc,
                  ir_en, addr_in, ram_addr_sel, mem_rd, mem_wr, ram_out, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NREG-1:0] oh(input logic [RSEL_W-1:0] idx);
        return NREG'(1) << idx;
    endfunction

    task automatic checkOutput(input string tag, input outs_t observed, input outs_t expected);
        tests++;
        if (observed !== expected) begin
            failed++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One control step: optional wait cycles with mem_ready low, then the completing cycle.
    task automatic applyStimulus(input string tag, input outs_t wait_exp, input outs_t done_exp,
                                 input int waits, input bit is_mem, input bit use_stat,
                                 input logic [3:0] stat);
        for (int i = 0; i < waits; i++) begin
            mem_ready = 1'b0;
            status    = 4'($urandom);
            @(negedge clk);
            checkOutput({tag, "_wait"}, obs, wait_exp);
            tick();
        end
        mem_ready = is_mem ? 1'b1 : 1'($urandom);
        status    = use_stat ? stat : 4'($urandom);
        @(negedge clk);
        checkOutput(tag, obs, done_exp);
        tick();
    endtask

    task automatic doReset;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_ready = 1'($urandom);
            status    = 4'($urandom);
            instr     = 16'($urandom);
            @(negedge clk);
            checkOutput("reset", obs, '0);
            tick();
        end
        rst = 1'b1;
    endtask

    task automatic doFetch(input logic [DATA_W-1:0] word);
        outs_t w, d;
        w        = '0;
        w.mem_rd = 1'b1;
        d        = w;
        d.ir_en  = 1'b1;
        d.pc_inc = 1'b1;
        applyStimulus("fetch", w, d, $urandom_range(0, 2), 1'b1, 1'b0, 4'd0);
        instr = word;
    endtask

    // Reference behaviour: the cycle list each opcode produces, from the instruction table.
    task automatic execInstr(input logic [3:0] op, input logic [2:0] rx, input logic [2:0] ry,
                             input logic [3:0] stat, input int mem_waits);
        outs_t a, b, c;
        doFetch({op, rx, ry, 6'($urandom)});
        a = '0;
        b = '0;
        c = '0;
        case (op)
            4'd0: begin
                a.rout = oh(ry);
                a.rin  = oh(rx);
                applyStimulus("mv_t1", a, a, 0, 1'b0, 1'b0, 4'd0);
            end
            4'd1: begin
                a.mem_rd  = 1'b1;
                b         = a;
                b.ram_out = 1'b1;
                b.rin     = oh(rx);
                b.pc_inc  = 1'b1;
                applyStimulus("mvi_t1", a, b, mem_waits, 1'b1, 1'b0, 4'd0);
            end
            4'd2, 4'd3, 4'd4: begin
                a.rout    = oh(rx);
                a.a_in    = 1'b1;
                applyStimulus("alu_t1", a, a, 0, 1'b0, 1'b0, 4'd0);
                b.rout    = oh(ry);
                b.gin     = 1'b1;
                b.addsub  = (op == 4'd3);
                b.xorctrl = (op == 4'd4);
                applyStimulus("alu_t2", b, b, 0, 1'b0, 1'b0, 4'd0);
                c.gout    = 1'b1;
                c.rin     = oh(rx);
                applyStimulus("alu_t3", c, c, 0, 1'b0, 1'b0, 4'd0);
            end
            4'd5: begin
                a.rout         = oh(ry);
                a.addr_in      = 1'b1;
                applyStimulus("ld_t1", a, a, 0, 1'b0, 1'b0, 4'd0);
                b.ram_addr_sel = 1'b1;
                b.mem_rd       = 1'b1;
                c              = b;
                c.ram_out      = 1'b1;
                c.rin          = oh(rx);
                applyStimulus("ld_t2", b, c, mem_waits, 1'b1, 1'b0, 4'd0);
            end
            4'd6: begin
                a.rout         = oh(ry);
                a.addr_in      = 1'b1;
                applyStimulus("st_t1", a, a, 0, 1'b0, 1'b0, 4'd0);
                b.rout         = oh(rx);
                b.ram_addr_sel = 1'b1;
                b.mem_wr       = 1'b1;
                applyStimulus("st_t2", b, b, mem_waits, 1'b1, 1'b0, 4'd0);
            end
            4'd7: begin
                if (ry[2] || stat[ry[1:0]]) begin
                    a.rout  = oh(rx);
                    a.pc_in = 1'b1;
                end
                applyStimulus("br_t1", a, a, 0, 1'b0, 1'b1, stat);
            end
            4'd8: begin
                applyStimulus("halt_t1", a, a, 0, 1'b0, 1'b0, 4'd0);
                b.halted = 1'b1;
                for (int i = 0; i < 12; i++) begin
                    applyStimulus("halted", b, b, 0, 1'b0, 1'b0, 4'd0);
                end
                doReset();
            end
            default: applyStimulus("nop_t1", a, a, 0, 1'b0, 1'b0, 4'd0);
        endcase
    endtask

    initial begin
        outs_t e;
        rst       = 1'b0;
        instr     = '0;
        status    = '0;
        mem_ready = 1'b0;
        #1;
        doReset();

        execInstr(4'd0, 3'd2, 3'd5, 4'd0, 0);
        execInstr(4'd3, 3'd1, 3'd3, 4'd0, 0);
        execInstr(4'd5, 3'd6, 3'd2, 4'd0, 3);
        execInstr(4'd7, 3'd4, 3'b000, 4'b0001, 0);
        execInstr(4'd7, 3'd4, 3'b001, 4'b0001, 0);
        execInstr(4'd7, 3'd4, 3'b100, 4'($urandom), 0);
        execInstr(4'd4, 3'd7, 3'd0, 4'd0, 0);
        execInstr(4'd1, 3'd3, 3'd0, 4'd0, 2);

        // Reset asserted while a store is stalled waiting for memory.
        doFetch({4'd6, 3'd1, 3'd2, 6'd0});
        e         = '0;
        e.rout    = oh(3'd2);
        e.addr_in = 1'b1;
        applyStimulus("st_t1", e, e, 0, 1'b0, 1'b0, 4'd0);
        mem_ready = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        checkOutput("st_mid_reset", obs, '0);
        tick();
        rst = 1'b1;
        execInstr(4'd12, 3'd0, 3'd0, 4'd0, 0);

        execInstr(4'd8, 3'd0, 3'd0, 4'd0, 0);

        for (int n = 0; n < 150; n++) begin
            execInstr(4'($urandom), 3'($urandom), 3'($urandom), 4'($urandom),
                      $urandom_range(0, 3));
        end
        doFetch('0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/seq_control_unit.md
SEQ_CONTROL_UNIT -- requirements
Module: seq_control_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning instruction and datapath width.
REQ-002 The block SHALL have parameter RSEL_W, default 3, meaning register-select field width; NREG = 2**RSEL_W registers; legal only if RSEL_W >= 3 and DATA_W >= 4 + 2*RSEL_W.
REQ-003 The block SHALL have these ports, as name, direction, width, meaning:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- instr  in  DATA_W  IR contents; opcode = instr[DATA_W-1:DATA_W-4], rx = next RSEL_W bits, ry = following RSEL_W bits.
- status  in  4  flags {V,C,N,Z} = status[3:0].
- mem_ready  in  1  memory access completes this cycle.
- rin  out  NREG  one-hot register load.
- rout  out  NREG  one-hot register bus drive.
- a_in, gin, gout  out  1 each  A-reg load, G-reg load, G-reg bus drive.
- addsub, xorctrl  out  1 each  ALU op: addsub=1 subtract; xorctrl=1 XOR.
- pc_in, pc_inc, ir_en, addr_in  out  1 each  PC load from bus, PC+1, IR load from memory, address-reg load from bus.
- ram_addr_sel  out  1  0 = PC addresses memory, 1 = address reg.
- mem_rd, mem_wr, ram_out  out  1 each  read strobe, write strobe, memory data drives bus.
- halted  out  1  HALT state reached.

Function
REQ-004 Opcodes SHALL be: 0 MV, 1 MVI, 2 ADD, 3 SUB, 4 XOR, 5 LD, 6 ST, 7 BR, 8 HALT; 9-15 NOP.
REQ-005 The FSM SHALL have states FETCH, T1, T2, T3, HALT; outputs are a combinational function of state, instr, status and mem_ready.
REQ-006 FETCH: ram_addr_sel=0, mem_rd=1; when mem_ready=1: ir_en=1, pc_inc=1, next state T1; else remain in FETCH.
REQ-007 MV: T1 asserts rout[ry], rin[rx], then FETCH.
REQ-008 MVI (two-word): T1 asserts ram_addr_sel=0, mem_rd=1, holds until mem_ready; on mem_ready asserts ram_out, rin[rx], pc_inc, then FETCH.
REQ-009 ADD/SUB/XOR: T1 asserts rout[rx], a_in; T2 asserts rout[ry], gin, with addsub=1 for SUB and xorctrl=1 for XOR; T3 asserts gout, rin[rx], then FETCH.
REQ-010 LD: T1 asserts rout[ry], addr_in; T2 asserts ram_addr_sel=1, mem_rd=1, holds until mem_ready; on mem_ready asserts ram_out, rin[rx], then FETCH.
REQ-011 ST: T1 asserts rout[ry], addr_in; T2 asserts rout[rx], ram_addr_sel=1, mem_wr=1, holds until mem_ready, then FETCH.
REQ-012 BR: condition is true if ry MSB = 1, else status[ry[1:0]]; if true, T1 asserts rout[rx], pc_in; if false, T1 asserts nothing; both then FETCH.
REQ-013 HALT and NOP: HALT goes T1 -> HALT; NOP goes T1 -> FETCH; HALT state asserts halted=1 and no other output, and is exited only by reset.
REQ-014 In every cycle, at most one of the rout bits, gout and ram_out SHALL be asserted; mem_rd and mem_wr SHALL never both be asserted; rin SHALL have at most one bit set.
REQ-015 Wait states SHALL be unbounded; the held outputs SHALL stay constant while mem_ready=0.
REQ-016 status SHALL be sampled only in BR T1; a flag change in any other state SHALL have no effect.

Reset
REQ-017 On a rising clk with rst=0, the state SHALL become FETCH, regardless of the current state or any pending wait.
REQ-018 While rst=0, every output SHALL be 0, including mem_rd and mem_wr mid-access.
REQ-019 In the first cycle after rst returns to 1, the FETCH outputs SHALL appear (mem_rd=1, ram_addr_sel=0).

Verification
REQ-020 Reset then MV (opcode 0, rx=2, ry=5), mem_ready=1 -> FETCH 1 cycle; T1 rin=8'b00000100, rout=8'b00100000; then FETCH.
REQ-021 SUB (rx=1, ry=3) -> T1 rout[1], a_in; T2 rout[3], gin, addsub=1, xorctrl=0; T3 gout, rin[1]; total 4 cycles.
REQ-022 LD with mem_ready held low 3 cycles in T2 -> mem_rd=1, ram_addr_sel=1 stable for 3 cycles, no rin; ram_out and rin[rx] in the mem_ready cycle.
REQ-023 BR rx=4: with ry=3'b000, status=4'b0001 -> pc_in, rout[4]; with ry=3'b001, status=4'b0001 -> no outputs; with ry=3'b100 -> taken for any status.
REQ-024 ST with rst driven 0 during T2 while mem_ready=0 -> mem_wr=0 in that cycle; FETCH outputs in the cycle after rst=1.
REQ-025 HALT -> halted=1 persists for 10+ cycles with all other outputs 0; clears only after reset.
